input_conditioner: RTL
======================

Name: input_conditioner

Overview:
Parametrised front end for the traffic-light controller's asynchronous inputs: Sensor, Walk_Request, Reprogram and similar. Each channel gets an N-stage synchroniser, optional debounce, rising-edge pulse detection and an optional sticky request latch. The block also produces a reset with asynchronous assertion and synchronous deassertion for the rest of the controller. It sits between the board pins and the FSM/timer blocks.

Parameters:
CHANNELS, 3, number of independent asynchronous inputs (>=1)
SYNC_STAGES, 2, flip-flops per synchroniser chain and per reset-sync chain (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a change (>=1); used only with INPUT_DEBOUNCE_EN
LATCH_MASK, 3'b010, CHANNELS-wide; bit=1 makes that channel's sync_held sticky

Ports:
clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
async_in  input  CHANNELS  raw asynchronous inputs
latch_clr  input  CHANNELS  synchronous clear of sticky latch, per channel
Reset_Sync  output  1  reset for downstream logic; asserts asynchronously, deasserts synchronously
sync_level  output  CHANNELS  synchronised (and optionally debounced) level
sync_rise  output  CHANNELS  one-cycle pulse on each 0->1 of sync_level
sync_held  output  CHANNELS  sticky request (masked channels); otherwise equals sync_level

Behaviour:
- Reset=1 (async): every flop is cleared to 0, except the reset chain, which is set to 1. Outputs are then Reset_Sync=1, sync_level=0, sync_rise=0, sync_held=0. Debounce counters are cleared to 0.
- Reset chain: SYNC_STAGES flops shift in 0 once Reset falls. Reset_Sync = last stage, so it drops at the SYNC_STAGES-th rising edge after Reset falls.
- Channel synchroniser:
  - Stage 1 samples async_in[i]; s[i] = last stage output.
  - Latency without debounce: SYNC_STAGES rising edges from the first edge that samples the new value.
  - Synchroniser flops are reset by Reset only and keep sampling while Reset_Sync=1.
- Level path: sync_level = s when debounce is compiled out; otherwise it is the debounced state d (see Optional Feature).
- Edge detector:
  - prev[i] is registered from sync_level[i], but held at 0 while Reset_Sync=1.
  - sync_rise = sync_level & ~prev & ~Reset_Sync.
  - The pulse lasts exactly one cycle per rise.
  - An input already high when Reset_Sync drops produces one sync_rise in the first cycle with Reset_Sync=0. The request is not lost.
- Sticky latch, channels with LATCH_MASK[i]=1:
  - held[i] is set at an edge where sync_rise[i]=1.
  - held[i] is cleared at an edge where latch_clr[i]=1.
  - Set and clear in the same cycle: set wins, held stays 1.
  - held[i] stays 1 after sync_level returns to 0.
- Non-masked channels: sync_held[i]=sync_level[i] combinationally. latch_clr[i] is ignored.
- Channels are fully independent. A single-cycle input pulse is not guaranteed capture (CDC); the input must be stable for at least 2 clk periods.
- Reset mid-operation: all state is cleared immediately, including held latches and counters. Recovery follows the reset-chain rule above.

Optional Feature:
- Macro: INPUT_DEBOUNCE_EN.
- Defined:
  - Each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1) and a state flop d, both reset to 0.
  - Each edge with s!=d: if count==DEBOUNCE_CYCLES-1, then d<=s and count<=0; otherwise count<=count+1.
  - Each edge with s==d: count<=0.
  - Total latency is SYNC_STAGES+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is filtered.
- Undefined: no counters; sync_level=s; DEBOUNCE_CYCLES has no effect.

Test Plan:
Defaults apply (CHANNELS=3, SYNC_STAGES=2, LATCH_MASK=3'b010), with a 6 ns clk period.
- Reset high 3 ns, then low -> Reset_Sync=1 at once and all outputs 0; Reset_Sync=0 at the 2nd rising edge after release.
- No debounce: async_in[0] 0->1 held 10 cycles -> sync_level[0]=1 after 2 edges; sync_rise[0]=1 for exactly 1 cycle; sync_held[0] mirrors level and falls 2 edges after input falls.
- async_in[1] high for 2 cycles, then low -> sync_held[1] stays 1 after sync_level[1]=0; latch_clr[1]=1 for 1 cycle -> sync_held[1]=0 at the next edge.
- latch_clr[1]=1 in the same cycle as sync_rise[1]=1 -> sync_held[1] remains 1; latch_clr[0] has no effect on channel 0.
- async_in[2]=1 throughout a Reset pulse -> no sync_rise while Reset_Sync=1; exactly one sync_rise[2] in the first cycle after Reset_Sync drops.
- INPUT_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle high glitch on async_in[2] -> sync_level[2] stays 0; 4-cycle-stable high -> sync_level[2]=1 at edge 6 (2+4), with one sync_rise[2].

Source files
------------

// File: rtl/input_conditioner.sv
// Board-pin front end: reset sync, per-channel synchroniser, optional debounce (INPUT_DEBOUNCE_EN),
// rising-edge pulse and optional sticky request latch.
module input_conditioner #(
  parameter int                  CHANNELS        = 3,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 4,
  parameter logic [CHANNELS-1:0] LATCH_MASK      = 3'b010
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CHANNELS-1:0] latch_clr,
  output logic                Reset_Sync,
  output logic [CHANNELS-1:0] sync_level,
  output logic [CHANNELS-1:0] sync_rise,
  output logic [CHANNELS-1:0] sync_held
);

  logic [SYNC_STAGES-1:0] rst_chain_q;
  logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]    sync_s;
  logic [CHANNELS-1:0]    prev_q, prev_d;
  logic [CHANNELS-1:0]    held_q, held_d;

  // Reset chain powers up asserted and shifts in zeros once Reset releases.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rst_chain_q <= '1;
    end else begin
      rst_chain_q <= {rst_chain_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign Reset_Sync = rst_chain_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] deb_q, deb_d;

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      deb_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sync_level = deb_q;
`else
  assign sync_level = sync_s;
`endif

  // prev stays 0 during Reset_Sync so a level already high at release still pulses once.
  assign prev_d    = Reset_Sync ? '0 : sync_level;
  assign sync_rise = sync_level & ~prev_q & {CHANNELS{~Reset_Sync}};

  // Set has priority over clear; unmasked channels never hold state.
  assign held_d    = ((held_q & ~latch_clr) | sync_rise) & LATCH_MASK;
  assign sync_held = (held_q & LATCH_MASK) | (sync_level & ~LATCH_MASK);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prev_q <= '0;
      held_q <= '0;
    end else begin
      prev_q <= prev_d;
      held_q <= held_d;
    end
  end

endmodule
